// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight producers with a decrementing Tnew and derives the
// ID stall, the ID-stage bypass selects and the mult/div busy interlock.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned TNEW_W     = 2,
  parameter int unsigned MD_LATENCY = 5,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [TNEW_W-1:0] id_tuse_rs,
  input  logic [TNEW_W-1:0] id_tuse_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr_en,
  input  logic [TNEW_W-1:0] id_tnew,
  input  logic              id_md_start,
  input  logic              id_md_use,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [REG_AW-1:0]     dst_q  [NUM_STAGES];
  logic [REG_AW-1:0]     dst_d  [NUM_STAGES];
  logic [TNEW_W-1:0]     tnew_q [NUM_STAGES];
  logic [TNEW_W-1:0]     tnew_d [NUM_STAGES];
  logic [7:0]            md_cnt_q, md_cnt_d;

  logic              rs_hit, rt_hit;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic [SEL_W-1:0]  rs_sel, rt_sel;
  logic              rs_stall, rt_stall;

  // Youngest (lowest stage) valid match wins; older matches are shadowed.
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = '0;
    rs_sel  = '0;
    rt_hit  = 1'b0;
    rt_tnew = '0;
    rt_sel  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!rs_hit && valid_q[k] && (id_rs != '0) && (dst_q[k] == id_rs)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[k];
        rs_sel  = SEL_W'(k + 1);
      end
      if (!rt_hit && valid_q[k] && (id_rt != '0) && (dst_q[k] == id_rt)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[k];
        rt_sel  = SEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    rs_stall   = rs_hit && (id_tuse_rs != '1) && (rs_tnew > id_tuse_rs);
    rt_stall   = rt_hit && (id_tuse_rt != '1) && (rt_tnew > id_tuse_rt);
    md_busy    = (md_cnt_q != 8'd0);
    stall      = rs_stall | rt_stall | (id_md_use & md_busy);
    fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_sel : '0;
    fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_sel : '0;
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = !stall && id_wr_en && (id_dst != '0);
    dst_d[0]   = id_dst;
    tnew_d[0]  = id_tnew;
    for (int k = 1; k < NUM_STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      dst_d[k]   = dst_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
    end

    if (id_md_start && !stall) begin
      md_cnt_d = 8'(MD_LATENCY);
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      md_cnt_q <= 8'd0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      md_cnt_q <= md_cnt_d;
      dst_q    <= dst_d;
      tnew_q   <= tnew_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard scoreboard for the pipelined MIPS core; it replaces the purely combinational Tuse/Tnew classification with a tracked producer pipeline. Each cycle it compares the decode-stage (ID) instruction's source registers and Tuse values against a shift pipeline of in-flight producers, each carrying a decrementing Tnew. From this it drives the F/D stall, the ID-stage bypass selects and a multi-cycle mult/div busy interlock. It sits in the controller between the decoder and the datapath forwarding muxes.

## Interface
Parameters:
- NUM_STAGES, 3: tracked producer stages after ID (stage 0 = E, 1 = M, 2 = W).
- REG_AW, 5: register address width.
- TNEW_W, 2: width of Tnew/Tuse fields.
- MD_LATENCY, 5: busy cycles of the mult/div unit after a start enters E (1..255).
- SEL_W, $clog2(NUM_STAGES+1): bypass select width.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- reset in 1: synchronous, active-high; clears all state.
- id_rs in REG_AW: ID source register rs.
- id_rt in REG_AW: ID source register rt.
- id_tuse_rs in TNEW_W: cycles until rs is needed; all-ones means rs unused.
- id_tuse_rt in TNEW_W: same for rt.
- id_dst in REG_AW: ID destination register.
- id_wr_en in 1: ID instruction writes id_dst.
- id_tnew in TNEW_W: Tnew of the ID instruction as seen when it reaches E.
- id_md_start in 1: ID instruction starts mult/div.
- id_md_use in 1: ID instruction reads or writes HI/LO, or starts mult/div.
- stall out 1: freeze PC and F/D; insert bubble into E.
- fwd_rs_sel out SEL_W: ID bypass for rs; 0 = register file, k+1 = stage k result.
- fwd_rt_sel out SEL_W: same for rt.
- md_busy out 1: mult/div counter nonzero.

## Operation
- State: NUM_STAGES entries {valid, dst, tnew}; an 8-bit md counter.
- Shift every cycle. Entries k>0 take entry k-1 with tnew decremented (saturating at 0). The entry leaving the last stage is dropped.
- Entry 0 load:
  - stall=0: {id_wr_en && id_dst!=0, id_dst, id_tnew}.
  - stall=1: bubble (valid=0).
- Match on rs (and likewise rt): the youngest valid entry (lowest k) with dst==id_rs; id_rs==0 never matches. Older matches are shadowed.
- Data stall (rs): match exists, tuse_rs not all-ones, and match.tnew > id_tuse_rs. The rt condition is analogous.
- Bypass (rs): match exists and match.tnew==0 → fwd_rs_sel=k+1, otherwise 0. If the match has tnew>0 and no stall is raised, the sel is 0 and downstream forwarding handles the operand.
- MD counter:
  - Loads MD_LATENCY when id_md_start && !stall.
  - Otherwise decrements if nonzero.
  - A load takes priority over a decrement.
- MD stall: id_md_use && md_busy.
- stall = rs data stall | rt data stall | MD stall.
- A stalled instruction is re-evaluated each cycle; no state records the stall itself.

## Timing
- stall, fwd_*_sel and md_busy are combinational from current state and ID inputs, with no added latency.
- Entry state updates one cycle after ID presentation.
- Reset (including mid-operation): all entries invalid, counter 0. The next cycle gives stall=0, fwd_*_sel=0 and md_busy=0, regardless of ID inputs other than self-consistent data hazards (none, since the scoreboard is empty).
- Simultaneous id_md_start with md_busy=1 is stalled by the MD stall (id_md_use is asserted). It therefore never restarts a running counter.
- A producer with tnew saturated at 0 keeps bypassing from each later stage until it leaves stage NUM_STAGES-1. After that the register file serves the value (the regfile provides write-through).
- Same-register producers in two stages: only the youngest is considered, both for stall and for sel.

## Test plan
Defaults throughout; the same scenarios are repeated with NUM_STAGES=4 and MD_LATENCY=3.
- Load-use:
  - Stimulus: lw $8 (tnew 2) in ID; next cycle addu reads $8 in rs (tuse 1).
  - Cycle 1: stall=1.
  - Cycle 2: entry1 tnew=1, stall=0, fwd_rs_sel=0.
- Branch after ALU:
  - Stimulus: addu $8 (tnew 1), then beq reads $8 in rt (tuse 0).
  - Cycle 1: stall=1.
  - Cycle 2: fwd_rt_sel=2 (M), stall=0.
- $0 and unused operands:
  - Stimulus: producer writes $0; consumer reads $0, and also a case with tuse all-ones on a matching register.
  - Required: stall=0 and fwd=0 in both cases.
- Shadowing:
  - Stimulus: addu $8 followed by lw $8; consumer reads $8 in rs with tuse 0.
  - Required: the stall is driven by the younger lw entry (tnew 2), not the older addu.
- Mult/div:
  - Stimulus: mult, then mflo held in ID.
  - Required: md_busy=1 and stall=1 for exactly 5 cycles, then stall=0.
  - Additional: a second mult issued while busy is also stalled.
- Reset mid-stall:
  - Stimulus: assert reset during a load-use stall and during md_busy.
  - Required: the cycle after reset shows stall=0, md_busy=0 and all sel=0.
